lsu_sram_responder: RTL and testbench

- Memory-side responder for the LSU load/store interface. Sits opposite the LSU, replacing the DPI paddr_read/paddr_write path with a synthesizable word-addressed SRAM model.
- Exposes independent AXI-lite-style read (AR/R) and write (AW/W/B) channels with valid/ready handshakes.
- Response latency is programmable, so the multicycle IFU/IDEXU/LSU/WBU handshake chain is exercised under stall.

---
 rtl/lsu_sram_responder.sv | 233 +++++++++++++++++++++++
 tb/tb_lsu_sram_responder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_sram_responder.sv
// lsu_sram_responder: word-addressed SRAM behind AXI-lite-style read (AR/R)
// and write (AW/W/B) channels, with a programmable response latency so the
// LSU side sees multicycle stalls.
module lsu_sram_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN   = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("lsu_sram_responder: LATENCY must be in 1..15");
    end
    if ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("lsu_sram_responder: DEPTH_WORDS must be a power of two");
    end

    // Unsigned offset compare also rejects addresses below BASE_ADDR (wraps high).
    function automatic logic addr_in_range(input logic [31:0] addr);
        return (addr - BASE_ADDR) < SPAN;
    endfunction

    // Byte address to word index; the two low address bits are ignored.
    function automatic logic [IDX_W-1:0] addr_index(input logic [31:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 2);
    endfunction

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} rd_state_e;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} wr_state_e;

    logic [31:0] mem_q [DEPTH_WORDS];

    rd_state_e   rd_state_q, rd_state_d;
    logic [3:0]  rd_cnt_q, rd_cnt_d;
    logic [31:0] rd_addr_q, rd_addr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;

    wr_state_e   wr_state_q, wr_state_d;
    logic [3:0]  wr_cnt_q, wr_cnt_d;
    logic        aw_lat_q, aw_lat_d;
    logic        w_lat_q, w_lat_d;
    logic [31:0] aw_addr_q, aw_addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        commit_s;

    // Read channel next state: accept AR, count down latency, sample array, hold until R handshake.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        rd_addr_d  = rd_addr_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: begin
                if (arvalid) begin
                    rd_addr_d  = araddr;
                    rd_cnt_d   = LAT_M1;
                    rd_state_d = R_WAIT;
                end else begin
                    rd_state_d = R_IDLE;
                end
            end
            R_WAIT: begin
                if (rd_cnt_q == 4'd0) begin
                    rd_state_d = R_RESP;
                    if (addr_in_range(rd_addr_q)) begin
                        rdata_d = mem_q[addr_index(rd_addr_q)];
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = 32'h0000_0000;
                        rresp_d = RESP_DECERR;
                    end
                end else begin
                    rd_cnt_d = rd_cnt_q - 4'd1;
                end
            end
            R_RESP: begin
                if (rready) begin
                    rd_state_d = R_IDLE;
                end else begin
                    rd_state_d = R_RESP;
                end
            end
            default: begin
                rd_state_d = R_IDLE;
            end
        endcase
    end

    // Write channel next state: latch AW and W independently, count latency, commit, hold B.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_cnt_d   = wr_cnt_q;
        aw_lat_d   = aw_lat_q;
        w_lat_d    = w_lat_q;
        aw_addr_d  = aw_addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        commit_s   = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (awvalid && !aw_lat_q) begin
                    aw_lat_d  = 1'b1;
                    aw_addr_d = awaddr;
                end else begin
                    aw_lat_d = aw_lat_q;
                end
                if (wvalid && !w_lat_q) begin
                    w_lat_d = 1'b1;
                    wdata_d = wdata;
                    wstrb_d = wstrb;
                end else begin
                    w_lat_d = w_lat_q;
                end
                if (aw_lat_d && w_lat_d) begin
                    wr_cnt_d   = LAT_M1;
                    wr_state_d = W_WAIT;
                end else begin
                    wr_state_d = W_IDLE;
                end
            end
            W_WAIT: begin
                if (wr_cnt_q == 4'd0) begin
                    commit_s   = 1'b1;
                    wr_state_d = W_RESP;
                    if (addr_in_range(aw_addr_q)) begin
                        bresp_d = RESP_OKAY;
                    end else begin
                        bresp_d = RESP_DECERR;
                    end
                end else begin
                    wr_cnt_d = wr_cnt_q - 4'd1;
                end
            end
            W_RESP: begin
                if (bready) begin
                    aw_lat_d   = 1'b0;
                    w_lat_d    = 1'b0;
                    wr_state_d = W_IDLE;
                end else begin
                    wr_state_d = W_RESP;
                end
            end
            default: begin
                wr_state_d = W_IDLE;
            end
        endcase
    end

    // State, counter, latch and response registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state_q <= R_IDLE;
            rd_cnt_q   <= 4'd0;
            rd_addr_q  <= 32'h0000_0000;
            rdata_q    <= 32'h0000_0000;
            rresp_q    <= 2'b00;
            wr_state_q <= W_IDLE;
            wr_cnt_q   <= 4'd0;
            aw_lat_q   <= 1'b0;
            w_lat_q    <= 1'b0;
            aw_addr_q  <= 32'h0000_0000;
            wdata_q    <= 32'h0000_0000;
            wstrb_q    <= 4'h0;
            bresp_q    <= 2'b00;
        end else begin
            rd_state_q <= rd_state_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_addr_q  <= rd_addr_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            wr_state_q <= wr_state_d;
            wr_cnt_q   <= wr_cnt_d;
            aw_lat_q   <= aw_lat_d;
            w_lat_q    <= w_lat_d;
            aw_addr_q  <= aw_addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
        end
    end

    // Array commit: byte lanes selected by the latched strobe, only for in-range addresses.
    // Not reset; commit_s is low while the write FSM is held in reset.
    always_ff @(posedge clk) begin
        if (commit_s && addr_in_range(aw_addr_q)) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) begin
                    mem_q[addr_index(aw_addr_q)][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign arready = (rd_state_q == R_IDLE);
    assign rvalid  = (rd_state_q == R_RESP);
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign awready = (wr_state_q == W_IDLE) && !aw_lat_q;
    assign wready  = (wr_state_q == W_IDLE) && !w_lat_q;
    assign bvalid  = (wr_state_q == W_RESP);
    assign bresp   = bresp_q;

endmodule

// File: tb/tb_lsu_sram_responder.sv
// Self-checking bench for lsu_sram_responder: a timestamp-based reference
// model is compared against every DUT output on every falling edge, and
// directed transactions carry hand-computed literal expectations.
module tb_lsu_sram_responder;

    localparam int          LAT   = 3;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr = 32'h0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] awaddr = 32'h0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  wstrb = 4'h0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;

    always #5 clk = ~clk;

    lsu_sram_responder #(
        .BASE_ADDR  (BASE),
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: memory image plus per-channel "busy / due edge" bookkeeping.
    logic [31:0] mmem [DEPTH];
    bit          r_busy, r_valid;
    int          r_due;
    logic [31:0] r_addr, m_rdata;
    logic [1:0]  m_rresp;
    bit          aw_have, w_have, b_valid;
    int          w_due;
    logic [31:0] m_awaddr, m_wdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp;

    function automatic bit in_rng(input logic [31:0] a);
        longint unsigned la, lb;
        la = longint'(a);
        lb = longint'(BASE);
        return (la >= lb) && (la < lb + longint'(4 * DEPTH));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) / 32'd4);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        r_busy = 1'b0; r_valid = 1'b0; r_due = 0; r_addr = 32'h0;
        m_rdata = 32'h0; m_rresp = 2'b00;
        aw_have = 1'b0; w_have = 1'b0; b_valid = 1'b0; w_due = 0;
        m_awaddr = 32'h0; m_wdata = 32'h0; m_wstrb = 4'h0; m_bresp = 2'b00;
    endtask

    // Advance the model by one rising edge using the inputs presented before it.
    task automatic model_edge();
        bit ar_rdy, rv, bv, both_pre;
        if (!rst) begin
            model_reset();
            return;
        end
        ar_rdy   = !r_busy;
        rv       = r_valid;
        bv       = b_valid;
        both_pre = aw_have && w_have;
        // read side samples memory before any same-edge write commit
        if (arvalid && ar_rdy) begin
            r_busy = 1'b1; r_due = cyc + LAT; r_addr = araddr;
        end else if (r_busy && !rv && cyc == r_due) begin
            r_valid = 1'b1;
            if (in_rng(r_addr)) begin
                m_rdata = mmem[widx(r_addr)]; m_rresp = 2'b00;
            end else begin
                m_rdata = 32'h0; m_rresp = 2'b11;
            end
        end else if (rv && rready) begin
            r_busy = 1'b0; r_valid = 1'b0;
        end
        if (!both_pre) begin
            if (awvalid && !aw_have) begin aw_have = 1'b1; m_awaddr = awaddr; end
            if (wvalid && !w_have) begin w_have = 1'b1; m_wdata = wdata; m_wstrb = wstrb; end
            if (aw_have && w_have) w_due = cyc + LAT;
        end else if (!bv && cyc == w_due) begin
            b_valid = 1'b1;
            if (in_rng(m_awaddr)) begin
                for (int i = 0; i < 4; i++)
                    if (m_wstrb[i]) mmem[widx(m_awaddr)][8*i +: 8] = m_wdata[8*i +: 8];
                m_bresp = 2'b00;
            end else begin
                m_bresp = 2'b11;
            end
        end else if (bv && bready) begin
            aw_have = 1'b0; w_have = 1'b0; b_valid = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("arready", 32'(arready), 32'(!r_busy));
        check("rvalid",  32'(rvalid),  32'(r_valid));
        check("rdata",   rdata,        m_rdata);
        check("rresp",   32'(rresp),   32'(m_rresp));
        check("awready", 32'(awready), 32'(!aw_have));
        check("wready",  32'(wready),  32'(!w_have));
        check("bvalid",  32'(bvalid),  32'(b_valid));
        check("bresp",   32'(bresp),   32'(m_bresp));
    endtask

    // One clock: model follows the rising edge, comparison on the falling edge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int w_delay, input int bhold, input logic [1:0] exp_resp);
        bit aw_done, w_done, done, awf, wf;
        int t_acc;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = (w_delay == 0); bready = 1'b0;
        aw_done = 1'b0; w_done = 1'b0; done = 1'b0; t_acc = -1;
        for (int k = 0; k < 40 && !done; k++) begin
            awf = awvalid && awready;
            wf  = wvalid && wready;
            tick();
            if (awf) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (wf)  begin wvalid  = 1'b0; w_done  = 1'b1; end
            if (aw_done && w_done && t_acc < 0) t_acc = cyc;
            if (!w_done && k + 1 == w_delay) wvalid = 1'b1;
            if (bvalid) done = 1'b1;
        end
        check("wr_done", 32'(done), 32'd1);
        check("wr_latency", 32'(cyc - t_acc), 32'(LAT));
        check("wr_bresp", 32'(bresp), 32'(exp_resp));
        for (int k = 0; k < bhold; k++) tick();
        check("wr_bvalid_held", 32'(bvalid), 32'd1);
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input int rhold);
        bit done, arf;
        int t_acc;
        araddr = a; arvalid = 1'b1; rready = 1'b0;
        done = 1'b0; t_acc = -1;
        for (int k = 0; k < 40 && !done; k++) begin
            arf = arvalid && arready;
            tick();
            if (arf) begin arvalid = 1'b0; t_acc = cyc; end
            if (rvalid) done = 1'b1;
        end
        check("rd_done", 32'(done), 32'd1);
        check("rd_latency", 32'(cyc - t_acc), 32'(LAT));
        check("rd_data", rdata, exp_data);
        check("rd_resp", 32'(rresp), 32'(exp_resp));
        for (int k = 0; k < rhold; k++) tick();
        check("rd_data_held", rdata, exp_data);
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    initial begin
        bit done;
        rst = 1'b1;
        model_reset();
        #1 rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        // reset state, pinned by literals
        check("rst_arready", 32'(arready), 32'd1);
        check("rst_awready", 32'(awready), 32'd1);
        check("rst_wready",  32'(wready),  32'd1);
        check("rst_rvalid",  32'(rvalid),  32'd0);
        check("rst_bvalid",  32'(bvalid),  32'd0);
        check("rst_rdata",   rdata,        32'h0);

        // full-word write then read back
        do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 2'b00);
        do_read (32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 0);
        // byte strobes 0101
        do_write(32'h8000_0010, 32'h1122_3344, 4'b0101, 0, 0, 2'b00);
        do_read (32'h8000_0010, 32'hDE22_BE44, 2'b00, 3);
        // wstrb=0: no update, still OKAY
        do_write(32'h8000_0010, 32'h0000_0000, 4'h0, 0, 0, 2'b00);
        do_read (32'h8000_0010, 32'hDE22_BE44, 2'b00, 0);
        // AW first, W four cycles later, B held off for five cycles
        do_write(32'h8000_0040, 32'hCAFE_F00D, 4'hF, 4, 5, 2'b00);
        do_read (32'h8000_0040, 32'hCAFE_F00D, 2'b00, 0);
        // out of range in both directions, word 0 must stay intact
        do_write(32'h8000_0000, 32'h0102_0304, 4'hF, 0, 0, 2'b00);
        do_write(32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 0, 2, 2'b11);
        do_read (32'h8000_0000, 32'h0102_0304, 2'b00, 0);
        do_read (32'h7FFF_FFFC, 32'h0000_0000, 2'b11, 2);
        do_read (32'h8000_1000, 32'h0000_0000, 2'b11, 0);
        // last word, and unaligned address into it
        do_write(32'h8000_0FFC, 32'h5A5A_A5A5, 4'hF, 0, 0, 2'b00);
        do_read (32'h8000_0FFF, 32'h5A5A_A5A5, 2'b00, 0);

        // same-edge read sample and write commit: read sees the old word
        do_write(32'h8000_0020, 32'hAAAA_5555, 4'hF, 0, 0, 2'b00);
        araddr = 32'h8000_0020; arvalid = 1'b1;
        awaddr = 32'h8000_0020; awvalid = 1'b1;
        wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            tick();
            if (rvalid || bvalid) done = 1'b1;
        end
        check("race_rvalid", 32'(rvalid), 32'd1);
        check("race_bvalid", 32'(bvalid), 32'd1);
        check("race_old_data", rdata, 32'hAAAA_5555);
        rready = 1'b1; bready = 1'b1;
        tick();
        rready = 1'b0; bready = 1'b0;
        do_read(32'h8000_0020, 32'h1234_5678, 2'b00, 0);

        // reset during W_WAIT: write dropped, nothing committed
        do_write(32'h8000_0030, 32'h0BAD_F00D, 4'hF, 0, 0, 2'b00);
        awaddr = 32'h8000_0030; awvalid = 1'b1;
        wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        check("mrst_bvalid",  32'(bvalid),  32'd0);
        check("mrst_awready", 32'(awready), 32'd1);
        check("mrst_wready",  32'(wready),  32'd1);
        do_read(32'h8000_0030, 32'h0BAD_F00D, 2'b00, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
